// File: rtl/fetch_stage_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_ctrl_pkg
// Description : Stage-control and PC-source codes shared by the hazard unit
//               and the fetch-side pipeline control, plus a PC alignment
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_ctrl_pkg;

    // Stage-control codes driven by the hazard unit (2'b11 behaves as HOLD)
    localparam logic [1:0] CTRL_NORMAL = 2'b00;
    localparam logic [1:0] CTRL_FLUSH  = 2'b01;
    localparam logic [1:0] CTRL_HOLD   = 2'b10;

    // ID-stage redirect source codes (2'b11 behaves as SEQ)
    localparam logic [1:0] PCSRC_SEQ   = 2'b00;
    localparam logic [1:0] PCSRC_JUMP  = 2'b01;
    localparam logic [1:0] PCSRC_JR    = 2'b10;

    // Instruction inserted as a pipeline bubble
    localparam logic [31:0] NOP = 32'h0000_0000;

    // HOLD is any code with the upper bit set, so 2'b11 holds as well
    function automatic logic is_hold(input logic [1:0] ctrl);
        return ctrl[1];
    endfunction

    // Every PC that reaches the register is word aligned
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage : fetch_stage_ctrl_pkg
`default_nettype wire

// File: rtl/fetch_stage_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Event counter that increments once per cycle while i_inc is
//               high and sticks at its all-ones value instead of wrapping.
// Ports       : clk     - clock, rising edge
//               rst_n   - asynchronous reset, active low
//               i_inc   - count this cycle
//               o_count - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = &r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/fetch_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_ctrl
// Description : Fetch-side pipeline control for a 5-stage MIPS core. Owns the
//               PC register and the IF/ID pipeline register and applies the
//               hazard unit's hold / flush / redirect codes to them. Also
//               keeps saturating stall and flush event counters.
// Ports       : clk, rst_n          - clock / async active-low reset
//               pc_ctrl, ifid_ctrl  - stage-control codes (NORMAL/FLUSH/HOLD)
//               pcsrc_id            - ID redirect select (jump / jr)
//               jump_target_id      - j/jal target
//               jr_target_id        - jr target (rs value)
//               branch_taken_ex     - EX resolved taken branch
//               branch_target_ex    - branch target
//               imem_rdata          - instruction at imem_addr, same cycle
//               imem_addr, pc_if    - PC register
//               ifid_instr/pc4/valid- IF/ID pipeline register
//               stall_cnt/flush_cnt - saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage_ctrl
    import fetch_stage_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       pc_ctrl,
    input  logic [1:0]       ifid_ctrl,
    input  logic [1:0]       pcsrc_id,
    input  logic [31:0]      jump_target_id,
    input  logic [31:0]      jr_target_id,
    input  logic             branch_taken_ex,
    input  logic [31:0]      branch_target_ex,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      imem_addr,
    output logic [31:0]      pc_if,
    output logic [31:0]      ifid_instr,
    output logic [31:0]      ifid_pc4,
    output logic             ifid_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [31:0] r_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc4;
    logic        r_ifid_valid;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;
    logic        w_ifid_hold;
    logic        w_ifid_flush;

    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_ifid_hold  = is_hold(ifid_ctrl);
    assign w_ifid_flush = (ifid_ctrl == CTRL_FLUSH);

    // The EX branch is older than the ID jump, so it wins when both fire.
    always_comb begin
        w_pc_next = w_pc_plus4;
        if (branch_taken_ex) begin
            w_pc_next = branch_target_ex;
        end else if (pcsrc_id == PCSRC_JUMP) begin
            w_pc_next = jump_target_id;
        end else if (pcsrc_id == PCSRC_JR) begin
            w_pc_next = jr_target_id;
        end
    end

    // FLUSH on the PC side behaves like NORMAL; only HOLD freezes it, and
    // a redirect presented during HOLD is deliberately discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= align_pc(RESET_PC);
        end else if (!is_hold(pc_ctrl)) begin
            r_pc <= align_pc(w_pc_next);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ifid_instr <= NOP;
            r_ifid_pc4   <= 32'h0;
            r_ifid_valid <= 1'b0;
        end else if (w_ifid_flush) begin
            r_ifid_instr <= NOP;
            r_ifid_pc4   <= 32'h0;
            r_ifid_valid <= 1'b0;
        end else if (!w_ifid_hold) begin
            r_ifid_instr <= imem_rdata;
            r_ifid_pc4   <= w_pc_plus4;
            r_ifid_valid <= 1'b1;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_ifid_hold),
        .o_count (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_ifid_flush),
        .o_count (flush_cnt)
    );

    assign pc_if      = r_pc;
    assign imem_addr  = r_pc;
    assign ifid_instr = r_ifid_instr;
    assign ifid_pc4   = r_ifid_pc4;
    assign ifid_valid = r_ifid_valid;

endmodule : fetch_stage_ctrl
`default_nettype wire

// File: tb/tb_fetch_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage_ctrl
// Description : Self-checking bench for fetch_stage_ctrl. A 16-bit-counter
//               instance and a 2-bit-counter instance share all stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  pc_ctrl = 2'b00;
    logic [1:0]  ifid_ctrl = 2'b00;
    logic [1:0]  pcsrc_id = 2'b00;
    logic [31:0] jump_target_id = '0;
    logic [31:0] jr_target_id = '0;
    logic        branch_taken_ex = 1'b0;
    logic [31:0] branch_target_ex = '0;
    logic [31:0] imem_rdata;

    logic [31:0] imem_addr, pc_if, ifid_instr, ifid_pc4;
    logic        ifid_valid;
    logic [15:0] stall_cnt, flush_cnt;

    logic [31:0] s_imem_addr, s_pc_if, s_ifid_instr, s_ifid_pc4;
    logic        s_ifid_valid;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    int          m_stall, m_flush;

    always #5 clk = ~clk;

    // Instruction memory content: a fixed scramble of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_stage_ctrl #(.RESET_PC(32'h0), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .pc_ctrl(pc_ctrl), .ifid_ctrl(ifid_ctrl),
        .pcsrc_id(pcsrc_id), .jump_target_id(jump_target_id),
        .jr_target_id(jr_target_id), .branch_taken_ex(branch_taken_ex),
        .branch_target_ex(branch_target_ex), .imem_rdata(imem_rdata),
        .imem_addr(imem_addr), .pc_if(pc_if), .ifid_instr(ifid_instr),
        .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    fetch_stage_ctrl #(.RESET_PC(32'h0), .CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .pc_ctrl(pc_ctrl), .ifid_ctrl(ifid_ctrl),
        .pcsrc_id(pcsrc_id), .jump_target_id(jump_target_id),
        .jr_target_id(jr_target_id), .branch_taken_ex(branch_taken_ex),
        .branch_target_ex(branch_target_ex), .imem_rdata(mem_word(s_imem_addr)),
        .imem_addr(s_imem_addr), .pc_if(s_pc_if), .ifid_instr(s_ifid_instr),
        .ifid_pc4(s_ifid_pc4), .ifid_valid(s_ifid_valid),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        m_stall = 0; m_flush = 0;
    endtask

    task automatic set_idle();
        pc_ctrl = 2'b00; ifid_ctrl = 2'b00; pcsrc_id = 2'b00;
        branch_taken_ex = 1'b0;
    endtask

    // One clock edge: compute the architectural effect of the current
    // inputs on the model, then advance past the edge.
    task automatic tick();
        logic [31:0] n_pc, n_instr, n_pc4;
        logic        n_valid;
        n_pc = m_pc; n_instr = m_instr; n_pc4 = m_pc4; n_valid = m_valid;
        if (pc_ctrl == 2'b00 || pc_ctrl == 2'b01) begin
            if (branch_taken_ex)     n_pc = branch_target_ex;
            else if (pcsrc_id == 1)  n_pc = jump_target_id;
            else if (pcsrc_id == 2)  n_pc = jr_target_id;
            else                     n_pc = m_pc + 32'd4;
            n_pc = n_pc & 32'hFFFF_FFFC;
        end
        if (ifid_ctrl == 2'b00) begin
            n_instr = mem_word(m_pc); n_pc4 = m_pc + 32'd4; n_valid = 1'b1;
        end else if (ifid_ctrl == 2'b01) begin
            n_instr = 32'h0; n_pc4 = 32'h0; n_valid = 1'b0;
        end
        if (ifid_ctrl >= 2'b10) m_stall = m_stall + 1;
        if (ifid_ctrl == 2'b01) m_flush = m_flush + 1;
        @(posedge clk);
        m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4; m_valid = n_valid;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; set_idle(); model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        n_checks++;
        if (pc_if !== 32'h0 || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_pc: got %h/%h want 0", pc_if, imem_addr);
        end
        n_checks++;
        if (ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0 || ifid_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_ifid: got %h %h %b want 0 0 0", ifid_instr, ifid_pc4, ifid_valid);
        end
        n_checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d %0d want 0 0", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr;
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp_addr = 32'(i * 4);
            n_checks++;
            if (imem_addr !== exp_addr) begin
                n_fail++; $display("FAIL seq_addr[%0d]: got %h want %h", i, imem_addr, exp_addr);
            end
            n_checks++;
            if (ifid_pc4 !== exp_addr || ifid_valid !== 1'b1 || ifid_instr !== mem_word(exp_addr - 32'd4)) begin
                n_fail++; $display("FAIL seq_ifid[%0d]: got %h %h %b want %h %h 1", i, ifid_instr, ifid_pc4, ifid_valid, mem_word(exp_addr - 32'd4), exp_addr);
            end
        end
    endtask

    task automatic test_load_use_hold();
        logic [31:0] instr0, pc40;
        instr0 = ifid_instr; pc40 = ifid_pc4;
        pc_ctrl = 2'b10; ifid_ctrl = 2'b10;
        pcsrc_id = 2'b01; jump_target_id = 32'h0000_0800;
        tick();
        pc_ctrl = 2'b11; ifid_ctrl = 2'b11;
        tick();
        set_idle();
        n_checks++;
        if (pc_if !== 32'h10 || imem_addr !== 32'h10) begin
            n_fail++; $display("FAIL hold_pc: got %h want 00000010", pc_if);
        end
        n_checks++;
        if (ifid_instr !== instr0 || ifid_pc4 !== pc40 || ifid_valid !== 1'b1) begin
            n_fail++; $display("FAIL hold_ifid: got %h %h want %h %h", ifid_instr, ifid_pc4, instr0, pc40);
        end
        n_checks++;
        if (stall_cnt !== 16'd2 || flush_cnt !== 16'd0) begin
            n_fail++; $display("FAIL hold_cnt: got %0d %0d want 2 0", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_jump_flush();
        pcsrc_id = 2'b01; jump_target_id = 32'h0000_0100; ifid_ctrl = 2'b01;
        tick();
        set_idle();
        n_checks++;
        if (pc_if !== 32'h100) begin
            n_fail++; $display("FAIL jump_pc: got %h want 00000100", pc_if);
        end
        n_checks++;
        if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0) begin
            n_fail++; $display("FAIL jump_bubble: got %h %h %b want 0 0 0", ifid_instr, ifid_pc4, ifid_valid);
        end
        n_checks++;
        if (flush_cnt !== 16'd1) begin
            n_fail++; $display("FAIL jump_flushcnt: got %0d want 1", flush_cnt);
        end
    endtask

    task automatic test_priority();
        branch_taken_ex = 1'b1; branch_target_ex = 32'h40;
        pcsrc_id = 2'b10; jr_target_id = 32'h80; ifid_ctrl = 2'b01;
        tick();
        set_idle();
        n_checks++;
        if (pc_if !== 32'h40) begin
            n_fail++; $display("FAIL branch_priority: got %h want 00000040", pc_if);
        end
    endtask

    task automatic test_wrap_and_jr();
        pcsrc_id = 2'b01; jump_target_id = 32'hFFFF_FFFC;
        tick();
        set_idle();
        n_checks++;
        if (pc_if !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_setup: got %h want fffffffc", pc_if);
        end
        tick();
        n_checks++;
        if (pc_if !== 32'h0 || ifid_pc4 !== 32'h0 || ifid_valid !== 1'b1) begin
            n_fail++; $display("FAIL wrap_pc: got %h pc4 %h want 0 0", pc_if, ifid_pc4);
        end
        pcsrc_id = 2'b10; jr_target_id = 32'h103;
        tick();
        set_idle();
        n_checks++;
        if (pc_if !== 32'h100) begin
            n_fail++; $display("FAIL jr_align: got %h want 00000100", pc_if);
        end
        // Redirect code 11 is no redirect
        pcsrc_id = 2'b11; jr_target_id = 32'h500; jump_target_id = 32'h600;
        tick();
        set_idle();
        n_checks++;
        if (pc_if !== 32'h104) begin
            n_fail++; $display("FAIL pcsrc11_seq: got %h want 00000104", pc_if);
        end
    endtask

    task automatic test_saturation();
        int base;
        base = m_stall;
        pc_ctrl = 2'b10; ifid_ctrl = 2'b10;
        repeat (5) tick();
        set_idle();
        n_checks++;
        if (s_stall_cnt !== 2'd3) begin
            n_fail++; $display("FAIL sat_small: got %0d want 3", s_stall_cnt);
        end
        n_checks++;
        if (stall_cnt !== 16'(base + 5)) begin
            n_fail++; $display("FAIL sat_wide: got %0d want %0d", stall_cnt, base + 5);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            pc_ctrl          = 2'($urandom_range(0, 3));
            ifid_ctrl        = 2'($urandom_range(0, 3));
            pcsrc_id         = 2'($urandom_range(0, 3));
            jump_target_id   = $urandom;
            jr_target_id     = $urandom;
            branch_taken_ex  = ($urandom_range(0, 4) == 0);
            branch_target_ex = $urandom;
            tick();
            n_checks++;
            if (pc_if !== m_pc || imem_addr !== m_pc || ifid_instr !== m_instr ||
                ifid_pc4 !== m_pc4 || ifid_valid !== m_valid ||
                stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush)) begin
                n_fail++;
                if (errs < 10)
                    $display("FAIL random[%0d]: got pc %h ir %h p4 %h v %b s %0d f %0d want pc %h ir %h p4 %h v %b s %0d f %0d",
                             i, pc_if, ifid_instr, ifid_pc4, ifid_valid, stall_cnt, flush_cnt,
                             m_pc, m_instr, m_pc4, m_valid, m_stall, m_flush);
                errs++;
            end
            n_checks++;
            if (s_stall_cnt !== 2'((m_stall > 3) ? 3 : m_stall) || s_flush_cnt !== 2'((m_flush > 3) ? 3 : m_flush)) begin
                n_fail++;
                if (errs < 10)
                    $display("FAIL random_small[%0d]: got %0d %0d want sat(%0d) sat(%0d)", i, s_stall_cnt, s_flush_cnt, m_stall, m_flush);
                errs++;
            end
        end
        set_idle();
    endtask

    task automatic test_async_reset();
        pc_ctrl = 2'b10; ifid_ctrl = 2'b10;
        tick();
        n_checks++;
        if (stall_cnt === 16'd0 || s_stall_cnt === 2'd0) begin
            n_fail++; $display("FAIL arst_setup: got %0d want nonzero", stall_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (pc_if !== 32'h0 || imem_addr !== 32'h0 || ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0 ||
            ifid_valid !== 1'b0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0 ||
            s_stall_cnt !== 2'd0 || s_pc_if !== 32'h0) begin
            n_fail++; $display("FAIL arst_values: got pc %h ir %h p4 %h v %b s %0d f %0d want all 0",
                               pc_if, ifid_instr, ifid_pc4, ifid_valid, stall_cnt, flush_cnt);
        end
        set_idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (pc_if !== 32'h4 || ifid_pc4 !== 32'h4 || ifid_valid !== 1'b1) begin
            n_fail++; $display("FAIL arst_resume: got %h %h %b want 4 4 1", pc_if, ifid_pc4, ifid_valid);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_load_use_hold();
        test_jump_flush();
        test_priority();
        test_wrap_and_jr();
        test_saturation();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_stage_ctrl
`default_nettype wire
